// File: rtl/wb_pkg.sv
// Shared defaults and drain-state encoding for the store write buffer.
package wb_pkg;

  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefWriteLat = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/wb_lookup.sv
// Store-to-load forwarding search: youngest valid entry whose address matches wins.
module wb_lookup #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][15:0]     addr,
  input  logic [DEPTH-1:0][15:0]     data,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [15:0]                ld_addr,
  output logic                       ld_hit,
  output logic [15:0]                ld_data
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [IdxW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + IdxW'(i);
      if (valid[idx] && (addr[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: coalescing FIFO of pending stores with load forwarding and a
// one-outstanding-write drain FSM towards main memory.
module store_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned WRITE_LAT = DefWriteLat
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [15:0] st_addr,
  input  logic [15:0] st_data,
  output logic        st_ready,
  input  logic [15:0] ld_addr,
  output logic        ld_hit,
  output logic [15:0] ld_data,
  output logic        wb_req,
  output logic [15:0] wb_addr,
  output logic [15:0] wb_data,
  input  logic        wb_ack,
  output logic        wb_idle
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned LatW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
  localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
  localparam logic [LatW-1:0] LatLoad = LatW'(WRITE_LAT - 1);

  logic [DEPTH-1:0][15:0] addr_q, data_q;
  logic [DEPTH-1:0]       valid_q;
  logic [IdxW-1:0]        head_q, tail_q, young_idx;
  logic [CntW-1:0]        count_q, count_d;
  logic [LatW-1:0]        lat_q, lat_d;
  drain_state_e           state_q, state_d;
  logic                   coalesce_hit, accept, push, pop, coal_wr;

  assign young_idx = tail_q - 1'b1;

  // The head is locked once the drain FSM has started presenting it to memory.
  assign coalesce_hit = (count_q != '0) && (addr_q[young_idx] == st_addr) &&
                        !((young_idx == head_q) && (state_q != StIdle));

  assign st_ready = (count_q < Full) | coalesce_hit;
  assign accept   = st_valid & st_ready;
  assign coal_wr  = accept & coalesce_hit;
  assign push     = accept & ~coalesce_hit;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    wb_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StIssue;
      end
      StIssue: begin
        wb_req = 1'b1;
        if (wb_ack) begin
          state_d = StWait;
          lat_d   = LatLoad;
        end
      end
      StWait: begin
        if (lat_q == '0) begin
          pop     = 1'b1;
          state_d = ((count_q > CntW'(1)) || push) ? StIssue : StIdle;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      count_q <= count_d;
      if (push) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end else if (coal_wr) begin
      data_q[young_idx] <= st_data;
    end
  end

  assign wb_addr = wb_req ? addr_q[head_q] : 16'h0000;
  assign wb_data = wb_req ? data_q[head_q] : 16'h0000;
  assign wb_idle = (count_q == '0) && (state_q == StIdle);

  wb_lookup #(
    .DEPTH(DEPTH)
  ) u_lookup (
    .valid   (valid_q),
    .addr    (addr_q),
    .data    (data_q),
    .head    (head_q),
    .ld_addr (ld_addr),
    .ld_hit  (ld_hit),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: expected memory writes go into a queue that a
// negedge monitor drains on every wb_req/wb_ack handshake.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [15:0] st_addr, st_data;
  logic        st_ready;
  logic [15:0] ld_addr;
  logic        ld_hit;
  logic [15:0] ld_data;
  logic        wb_req;
  logic [15:0] wb_addr, wb_data;
  logic        wb_ack;
  logic        wb_idle;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  store_write_buffer #(
    .DEPTH     (4),
    .WRITE_LAT (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_ack   (wb_ack),
    .wb_idle  (wb_idle)
  );

  // Memory-side monitor.
  always @(negedge clk) begin
    if (rst_n && wb_req && wb_ack) begin
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL mem_write: got %h/%h required no write", wb_addr, wb_data);
      end else begin
        e = exp_q.pop_front();
        if ({wb_addr, wb_data} === e) passed++;
        else $display("FAIL mem_write: got %h/%h required %h/%h",
                      wb_addr, wb_data, e[31:16], e[15:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [15:0] a, input logic [15:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    #1;
    check("st_ready on push", {31'd0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!wb_idle && n < 200) begin
      tick();
      n++;
    end
    check(name, {31'd0, wb_idle}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; wb_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("reset st_ready", {31'd0, st_ready}, 32'd1);
    check("reset ld_hit",   {31'd0, ld_hit},   32'd0);
    check("reset ld_data",  {16'd0, ld_data},  32'h0);
    check("reset wb_req",   {31'd0, wb_req},   32'd0);
    check("reset wb_addr",  {16'd0, wb_addr},  32'h0);
    check("reset wb_data",  {16'd0, wb_data},  32'h0);
    check("reset wb_idle",  {31'd0, wb_idle},  32'd1);

    // Single store, ack held high.
    wb_ack = 1'b1;
    exp_q.push_back({16'h0010, 16'hAAAA});
    push_store(16'h0010, 16'hAAAA);
    #1;
    check("t1 wb_req before issue", {31'd0, wb_req}, 32'd0);
    check("t1 wb_idle busy", {31'd0, wb_idle}, 32'd0);
    tick();
    check("t1 wb_req", {31'd0, wb_req}, 32'd1);
    check("t1 wb_addr", {16'd0, wb_addr}, 32'h0010);
    check("t1 wb_data", {16'd0, wb_data}, 32'hAAAA);
    n = 0;
    while (!wb_idle && n < 20) begin
      tick();
      n++;
    end
    check("t1 idle latency", n, 32'd5);

    // Fill, stall on a new address, coalesce into the youngest.
    wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) push_store(16'h0100 + 16'(i), 16'hB000 + 16'(i));
    st_valid = 1'b1; st_addr = 16'h0104; st_data = 16'hDEAD;
    #1;
    check("t2 full stall", {31'd0, st_ready}, 32'd0);
    tick();
    st_addr = 16'h0103; st_data = 16'hC333;
    #1;
    check("t2 coalesce ready", {31'd0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
    ld_addr = 16'h0103;
    #1;
    check("t2 fwd hit", {31'd0, ld_hit}, 32'd1);
    check("t2 fwd data", {16'd0, ld_data}, 32'hC333);
    ld_addr = 16'h0104;
    #1;
    check("t2 stalled not stored", {31'd0, ld_hit}, 32'd0);
    exp_q.push_back({16'h0100, 16'hB000});
    exp_q.push_back({16'h0101, 16'hB001});
    exp_q.push_back({16'h0102, 16'hB002});
    exp_q.push_back({16'h0103, 16'hC333});
    wb_ack = 1'b1;
    wait_idle("t2 drain");

    // Non-adjacent repeat allocates; youngest match forwards.
    wb_ack = 1'b0;
    push_store(16'h0020, 16'h1111);
    push_store(16'h0030, 16'h2222);
    push_store(16'h0020, 16'h3333);
    ld_addr = 16'h0020;
    #1;
    check("t3 fwd hit", {31'd0, ld_hit}, 32'd1);
    check("t3 fwd youngest", {16'd0, ld_data}, 32'h3333);
    ld_addr = 16'h0030;
    #1;
    check("t3 fwd 0030", {16'd0, ld_data}, 32'h2222);
    ld_addr = 16'h0040;
    #1;
    check("t3 miss hit", {31'd0, ld_hit}, 32'd0);
    check("t3 miss data", {16'd0, ld_data}, 32'h0);
    ld_addr = 16'h0050;
    st_valid = 1'b1; st_addr = 16'h0050; st_data = 16'h5555;
    #1;
    check("t3 same-cycle invisible", {31'd0, ld_hit}, 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    check("t3 next-cycle visible", {16'd0, ld_data}, 32'h5555);
    exp_q.push_back({16'h0020, 16'h1111});
    exp_q.push_back({16'h0030, 16'h2222});
    exp_q.push_back({16'h0020, 16'h3333});
    exp_q.push_back({16'h0050, 16'h5555});
    wb_ack = 1'b1;
    wait_idle("t3 drain");

    // Store to the in-flight head address must not coalesce.
    exp_q.push_back({16'h0060, 16'h6666});
    exp_q.push_back({16'h0060, 16'h7777});
    push_store(16'h0060, 16'h6666);
    tick();
    tick();
    push_store(16'h0060, 16'h7777);
    wait_idle("t4 drain");

    // Full buffer popping on the final WAIT cycle does not admit a new store.
    wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) push_store(16'h0200 + 16'(i), 16'hD000 + 16'(i));
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0200 + 16'(i), 16'hD000 + 16'(i)});
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    repeat (3) tick();
    st_valid = 1'b1; st_addr = 16'h0204; st_data = 16'hD004;
    #1;
    check("t5 wb_req low in wait", {31'd0, wb_req}, 32'd0);
    check("t5 refused on pop", {31'd0, st_ready}, 32'd0);
    tick();
    #1;
    check("t5 accepted after pop", {31'd0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
    wb_ack = 1'b1;
    wait_idle("t5 drain");

    // Reset in the middle of a drain discards everything.
    wb_ack = 1'b0;
    for (int i = 0; i < 3; i++) push_store(16'h0300 + 16'(i), 16'hE000 + 16'(i));
    exp_q.push_back({16'h0300, 16'hE000});
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    tick();
    rst_n = 1'b0;
    ld_addr = 16'h0301;
    tick();
    #1;
    check("t6 wb_req", {31'd0, wb_req}, 32'd0);
    check("t6 ld_hit", {31'd0, ld_hit}, 32'd0);
    check("t6 wb_idle", {31'd0, wb_idle}, 32'd1);
    check("t6 st_ready", {31'd0, st_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6 stays idle", {31'd0, wb_idle}, 32'd1);
    check("all writes seen", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
